video_pll_lock_sequencer: RTL and testbench
===========================================

// Module: video_pll_lock_sequencer
// PURPOSE
//  Sequences the 25 MHz video PLL (50 MHz refclk) through reset, lock acquisition and
//  lock qualification, then releases the video pipeline reset. Retries on lock timeout
//  and enters FAULT after MAX_RETRIES. Re-sequences on loss of lock. Runs in the 50 MHz
//  refclk domain. Drives the PLL rst pin; video_reset_n must be re-synchronised into outclk_0.
// PARAMETERS
//  RST_CYCLES     64       cycles pll_rst is held high per attempt (>=2)
//  LOCK_TIMEOUT   500000   cycles allowed in WAIT_LOCK before an attempt fails (10 ms @50 MHz)
//  STABLE_CYCLES  1024     consecutive lock_sync=1 cycles required before RUN (>=1)
//  MAX_RETRIES    3        failed attempts tolerated after the first; 0..15
// PORTS
//  clk            in   1   50 MHz reference clock (same net as PLL refclk)
//  reset_n        in   1   synchronous, active-low reset
//  pll_locked     in   1   PLL locked output, asynchronous to clk
//  restart        in   1   1-cycle pulse: abort and re-sequence from RESET_PLL
//  pll_rst        out  1   to PLL rst, active-high
//  video_reset_n  out  1   video pipeline reset, active-low, high only in RUN
//  ready          out  1   1 in RUN
//  fault          out  1   1 in FAULT
//  retry_cnt      out  4   failed attempts in current sequence
//  loss_cnt       out  8   lock losses seen in RUN, saturates at 255
//  state          out  3   RESET_PLL=0 WAIT_LOCK=1 STABLE=2 RUN=3 FAULT=4
// BEHAVIOUR
//  - All outputs registered. During and after reset_n=0: state=RESET_PLL, pll_rst=1,
//    video_reset_n=0, ready=0, fault=0, retry_cnt=0, loss_cnt=0, timers cleared.
//  - pll_locked passes through a 2-flop synchroniser -> lock_sync (2-cycle latency).
//    Reset clears the synchroniser flops.
//  - One shared timer. Cleared on every state change.
//  - RESET_PLL: pll_rst=1. After RST_CYCLES cycles in the state -> WAIT_LOCK.
//    pll_rst reads 0 from the first WAIT_LOCK cycle.
//  - WAIT_LOCK: pll_rst=0.
//    - lock_sync=1 -> STABLE.
//    - Timer reaches LOCK_TIMEOUT-1 with lock_sync=0:
//      - retry_cnt==MAX_RETRIES -> FAULT.
//      - Otherwise retry_cnt+1 -> RESET_PLL.
//    - Lock arriving on the timeout cycle wins (-> STABLE).
//  - STABLE: lock_sync=0 -> WAIT_LOCK, timer restarted, retry_cnt unchanged.
//    STABLE_CYCLES consecutive lock_sync=1 cycles -> RUN.
//  - RUN: video_reset_n=1, ready=1, retry_cnt cleared on entry.
//    lock_sync=0 -> RESET_PLL, loss_cnt+1 (saturating). Same edge: video_reset_n=0, ready=0.
//  - FAULT: pll_rst=1, fault=1, video_reset_n=0. Held until restart or reset_n.
//  - restart=1 in any state -> RESET_PLL, retry_cnt=0, loss_cnt kept.
//  - Priority: reset_n > restart > state transitions.
//  - restart coincident with lock loss in RUN: loss_cnt not incremented.
//  - restart while already in RESET_PLL restarts the RST_CYCLES count.
//  - Timer width: clog2(max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1). No wrap possible.
// TESTING (bench params RST_CYCLES=4 LOCK_TIMEOUT=20 STABLE_CYCLES=8 MAX_RETRIES=2)
//  1 Release reset_n. pll_locked=1 from cycle 10 -> pll_rst low after 4 cycles,
//    RUN/video_reset_n=1 after 2 sync + 8 stable cycles, retry_cnt=0.
//  2 pll_locked stuck 0 -> 3 attempts, retry_cnt 1,2 then FAULT at cycle 3*(4+20).
//    pll_rst=1, fault=1. Then restart pulse -> RESET_PLL, retry_cnt=0, fault=0.
//  3 In STABLE, drop pll_locked for 1 cycle at stable count 5 -> back to WAIT_LOCK.
//    No RUN until 8 fresh consecutive cycles.
//  4 In RUN, drop pll_locked -> 2 cycles later state=RESET_PLL, video_reset_n=0,
//    loss_cnt=1. Repeat 300x -> loss_cnt=255.
//  5 restart coincident with lock loss in RUN -> RESET_PLL, loss_cnt unchanged.
//  6 reset_n low mid-WAIT_LOCK with retry_cnt=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/video_pll_lock_sequencer.sv
// Video PLL lock sequencer.
// Sequences the video PLL through reset, lock acquisition and lock
// qualification, then releases the video pipeline reset. A failed lock attempt
// is retried until the retry budget runs out, after which the block parks in
// FAULT. Losing lock while running sends the PLL back through the whole
// sequence. Everything runs in the PLL reference clock domain.
// video_reset_n is not synchronous to the PLL output clock, so the consumer
// must re-synchronise it there.

module video_pll_lock_sequencer #(
    parameter int RST_CYCLES    = 64,
    parameter int LOCK_TIMEOUT  = 500000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_rst,
    output logic       video_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt,
    output logic [2:0] state
);

    // One timer serves every timed state. It only ever counts up to the
    // longest interval minus one, so it never wraps.
    localparam int MAX_AB    = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL   = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int TIMER_W   = $clog2(MAX_ALL + 1);

    localparam logic [TIMER_W-1:0] RST_LAST     = TIMER_W'(RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST  = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]         RETRY_LIMIT  = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t               cur_state;
    state_t               nxt_state;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;
    logic [3:0]           retry_nxt;
    logic [7:0]           loss_nxt;
    logic                 pll_rst_nxt;
    logic                 video_reset_n_nxt;
    logic                 ready_nxt;
    logic                 fault_nxt;
    logic                 lock_meta;
    logic                 lock_sync;

    // Two-flop synchroniser bringing the asynchronous PLL lock flag into clk.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    // Next-state, timer and counter logic; restart overrides all transitions.
    always_comb begin
        nxt_state = cur_state;
        timer_nxt = timer;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;

        if (restart) begin
            nxt_state = S_RESET_PLL;
            timer_nxt = '0;
            retry_nxt = 4'd0;
        end else begin
            case (cur_state)
                S_RESET_PLL: begin
                    if (timer == RST_LAST) begin
                        nxt_state = S_WAIT_LOCK;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end

                S_WAIT_LOCK: begin
                    if (lock_sync) begin
                        nxt_state = S_STABLE;
                        timer_nxt = '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        timer_nxt = '0;
                        if (retry_cnt == RETRY_LIMIT) begin
                            nxt_state = S_FAULT;
                        end else begin
                            nxt_state = S_RESET_PLL;
                            retry_nxt = retry_cnt + 4'd1;
                        end
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end

                S_STABLE: begin
                    if (!lock_sync) begin
                        nxt_state = S_WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer == STABLE_LAST) begin
                        nxt_state = S_RUN;
                        timer_nxt = '0;
                        retry_nxt = 4'd0;
                    end else begin
                        timer_nxt = timer + 1'b1;
                    end
                end

                S_RUN: begin
                    timer_nxt = '0;
                    if (!lock_sync) begin
                        nxt_state = S_RESET_PLL;
                        if (loss_cnt != 8'hFF) begin
                            loss_nxt = loss_cnt + 8'd1;
                        end
                    end
                end

                S_FAULT: begin
                    timer_nxt = '0;
                end

                default: begin
                    nxt_state = S_RESET_PLL;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Output values decoded from the upcoming state so they register on the same edge.
    always_comb begin
        pll_rst_nxt       = 1'b0;
        video_reset_n_nxt = 1'b0;
        ready_nxt         = 1'b0;
        fault_nxt         = 1'b0;
        case (nxt_state)
            S_RESET_PLL: pll_rst_nxt = 1'b1;
            S_RUN: begin
                video_reset_n_nxt = 1'b1;
                ready_nxt         = 1'b1;
            end
            S_FAULT: begin
                pll_rst_nxt = 1'b1;
                fault_nxt   = 1'b1;
            end
            default: pll_rst_nxt = 1'b0;
        endcase
    end

    // State, timer, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cur_state     <= S_RESET_PLL;
            timer         <= '0;
            retry_cnt     <= 4'd0;
            loss_cnt      <= 8'd0;
            pll_rst       <= 1'b1;
            video_reset_n <= 1'b0;
            ready         <= 1'b0;
            fault         <= 1'b0;
        end else begin
            cur_state     <= nxt_state;
            timer         <= timer_nxt;
            retry_cnt     <= retry_nxt;
            loss_cnt      <= loss_nxt;
            pll_rst       <= pll_rst_nxt;
            video_reset_n <= video_reset_n_nxt;
            ready         <= ready_nxt;
            fault         <= fault_nxt;
        end
    end

    assign state = cur_state;

endmodule

// File: tb/tb_video_pll_lock_sequencer.sv
// Testbench for video_pll_lock_sequencer with a behavioural reference model.

module tb_video_pll_lock_sequencer;

    localparam int P_RST    = 4;
    localparam int P_TO     = 20;
    localparam int P_STABLE = 8;
    localparam int P_MAXR   = 2;

    localparam int ST_RESET  = 0;
    localparam int ST_WAIT   = 1;
    localparam int ST_STABLE = 2;
    localparam int ST_RUN    = 3;
    localparam int ST_FAULT  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst;
    logic       video_reset_n;
    logic       ready;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;
    logic [2:0] state;

    int errors = 0;
    int checks = 0;

    int m_mode = 0;
    int m_age = 0;
    int m_retries = 0;
    int m_losses = 0;
    int m_s1 = 0;
    int m_s2 = 0;

    logic [18:0] dut_vec;
    assign dut_vec = {state, pll_rst, video_reset_n, ready, fault, retry_cnt, loss_cnt};

    video_pll_lock_sequencer #(
        .RST_CYCLES(P_RST),
        .LOCK_TIMEOUT(P_TO),
        .STABLE_CYCLES(P_STABLE),
        .MAX_RETRIES(P_MAXR)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .pll_locked(pll_locked),
        .restart(restart),
        .pll_rst(pll_rst),
        .video_reset_n(video_reset_n),
        .ready(ready),
        .fault(fault),
        .retry_cnt(retry_cnt),
        .loss_cnt(loss_cnt),
        .state(state)
    );

    always #10 clk = ~clk;

    // Reference model: tracks phase, cycles spent in it, retries and losses.
    always @(posedge clk) begin
        int ls;
        ls = m_s2;
        if (!reset_n) begin
            m_mode = ST_RESET; m_age = 0; m_retries = 0; m_losses = 0;
            m_s1 = 0; m_s2 = 0;
        end else begin
            m_s2 = m_s1;
            m_s1 = int'(pll_locked);
            if (restart) begin
                m_mode = ST_RESET; m_age = 0; m_retries = 0;
            end else if (m_mode == ST_RESET) begin
                if (m_age + 1 >= P_RST) begin m_mode = ST_WAIT; m_age = 0; end
                else m_age++;
            end else if (m_mode == ST_WAIT) begin
                if (ls == 1) begin m_mode = ST_STABLE; m_age = 0; end
                else if (m_age + 1 >= P_TO) begin
                    m_age = 0;
                    if (m_retries >= P_MAXR) m_mode = ST_FAULT;
                    else begin m_retries++; m_mode = ST_RESET; end
                end else m_age++;
            end else if (m_mode == ST_STABLE) begin
                if (ls == 0) begin m_mode = ST_WAIT; m_age = 0; end
                else if (m_age + 1 >= P_STABLE) begin m_mode = ST_RUN; m_age = 0; m_retries = 0; end
                else m_age++;
            end else if (m_mode == ST_RUN) begin
                if (ls == 0) begin
                    m_mode = ST_RESET; m_age = 0;
                    m_losses = (m_losses >= 255) ? 255 : m_losses + 1;
                end
            end
        end
    end

    function automatic logic [18:0] expected_vec();
        logic e_rst, e_run, e_fault;
        e_rst   = (m_mode == ST_RESET) || (m_mode == ST_FAULT);
        e_run   = (m_mode == ST_RUN);
        e_fault = (m_mode == ST_FAULT);
        return {3'(m_mode), e_rst, e_run, e_run, e_fault, 4'(m_retries), 8'(m_losses)};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; restart = 1'b0; pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; restart = 1'b0; pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got %h expected %h", dut_vec, {3'd0, 4'b1000, 4'd0, 8'd0});
        end
        checks++;
        if (dut_vec !== expected_vec()) begin
            errors++;
            $display("[TB] FAIL reset_model: got %h expected %h", dut_vec, expected_vec());
        end
        reset_n = 1'b1;
    endtask

    task automatic test_lock_up();
        do_reset();
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL lock_up_model cyc %0d: got %h expected %h", k, dut_vec, expected_vec());
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (pll_rst !== (k == 3)) begin
                    errors++;
                    $display("[TB] FAIL lock_up_pll_rst cyc %0d: got %b expected %b", k, pll_rst, k == 3);
                end
            end
            if (k == 19 || k == 20) begin
                checks++;
                if ({ready, video_reset_n} !== {2{k == 20}}) begin
                    errors++;
                    $display("[TB] FAIL lock_up_run cyc %0d: got %b%b expected %b", k, ready, video_reset_n, k == 20);
                end
            end
            if (k == 20) begin
                checks++;
                if (retry_cnt !== 4'd0) begin
                    errors++;
                    $display("[TB] FAIL lock_up_retry: got %0d expected 0", retry_cnt);
                end
            end
            if (k == 9) pll_locked = 1'b1;
        end
    endtask

    task automatic test_retry_fault();
        do_reset();
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL retry_model cyc %0d: got %h expected %h", k, dut_vec, expected_vec());
            end
            if (k == 24 || k == 48) begin
                checks++;
                if ({state, retry_cnt} !== {3'd0, 4'(k / 24)}) begin
                    errors++;
                    $display("[TB] FAIL retry_count cyc %0d: got state %0d retry %0d expected state 0 retry %0d", k, state, retry_cnt, k / 24);
                end
            end
            if (k == 71) begin
                checks++;
                if (state !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL retry_prefault: got state %0d expected 1", state);
                end
            end
            if (k == 72) begin
                checks++;
                if ({state, pll_rst, fault, video_reset_n} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
                    errors++;
                    $display("[TB] FAIL retry_fault: got state %0d rst %b fault %b vrn %b expected 4 1 1 0", state, pll_rst, fault, video_reset_n);
                end
            end
        end
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if ({state, retry_cnt, fault, pll_rst} !== {3'd0, 4'd0, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL fault_restart: got state %0d retry %0d fault %b rst %b expected 0 0 0 1", state, retry_cnt, fault, pll_rst);
        end
    endtask

    task automatic test_stable_glitch();
        do_reset();
        pll_locked = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL glitch_model cyc %0d: got %h expected %h", k, dut_vec, expected_vec());
            end
            if (k == 10) begin
                checks++;
                if (state !== 3'd1) begin
                    errors++;
                    $display("[TB] FAIL glitch_back_to_wait: got state %0d expected 1", state);
                end
            end
            if (k == 13 || k == 18 || k == 19) begin
                checks++;
                if (ready !== (k == 19)) begin
                    errors++;
                    $display("[TB] FAIL glitch_ready cyc %0d: got %b expected %b", k, ready, k == 19);
                end
            end
            pll_locked = (k == 7) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_loss_count();
        int n;
        do_reset();
        pll_locked = 1'b1;
        for (int i = 0; i < 300; i++) begin
            n = 0;
            while (ready !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
                checks++;
                if (dut_vec !== expected_vec()) begin
                    errors++;
                    $display("[TB] FAIL loss_model iter %0d: got %h expected %h", i, dut_vec, expected_vec());
                end
            end
            checks++;
            if (ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL loss_reach_run iter %0d: got ready %b expected 1", i, ready);
            end
            pll_locked = 1'b0;
            @(negedge clk);
            pll_locked = 1'b1;
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({state, video_reset_n, ready, loss_cnt} !== {3'd0, 1'b0, 1'b0, 8'((i + 1 > 255) ? 255 : i + 1)}) begin
                errors++;
                $display("[TB] FAIL loss_event iter %0d: got state %0d vrn %b ready %b loss %0d expected 0 0 0 %0d",
                         i, state, video_reset_n, ready, loss_cnt, (i + 1 > 255) ? 255 : i + 1);
            end
        end
        checks++;
        if (loss_cnt !== 8'd255) begin
            errors++;
            $display("[TB] FAIL loss_saturate: got %0d expected 255", loss_cnt);
        end
    endtask

    task automatic test_restart_on_loss();
        int n;
        do_reset();
        pll_locked = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_loss_reach_run: got ready %b expected 1", ready);
        end
        pll_locked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        pll_locked = 1'b1;
        checks++;
        if ({state, loss_cnt, retry_cnt, ready} !== {3'd0, 8'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL restart_loss: got state %0d loss %0d retry %0d ready %b expected 0 0 0 0", state, loss_cnt, retry_cnt, ready);
        end
        checks++;
        if (dut_vec !== expected_vec()) begin
            errors++;
            $display("[TB] FAIL restart_loss_model: got %h expected %h", dut_vec, expected_vec());
        end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL midwait_model cyc %0d: got %h expected %h", k, dut_vec, expected_vec());
            end
        end
        checks++;
        if ({state, retry_cnt} !== {3'd1, 4'd1}) begin
            errors++;
            $display("[TB] FAIL midwait_setup: got state %0d retry %0d expected 1 1", state, retry_cnt);
        end
        reset_n = 1'b0;
        @(negedge clk);
        checks++;
        if (dut_vec !== {3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0}) begin
            errors++;
            $display("[TB] FAIL midwait_reset: got %h expected %h", dut_vec, {3'd0, 4'b1000, 4'd0, 8'd0});
        end
        reset_n = 1'b1;
    endtask

    task automatic test_random();
        int run_left;
        run_left = 0;
        do_reset();
        for (int k = 0; k < 2500; k++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== expected_vec()) begin
                errors++;
                $display("[TB] FAIL random_model cyc %0d: got %h expected %h", k, dut_vec, expected_vec());
            end
            if (run_left == 0) begin
                pll_locked = ($urandom_range(0, 3) != 0);
                if (pll_locked) run_left = $urandom_range(1, 40);
                else if ($urandom_range(0, 4) == 0) run_left = $urandom_range(20, 90);
                else run_left = $urandom_range(1, 3);
            end
            run_left--;
            restart = ($urandom_range(0, 149) == 0);
            reset_n = ($urandom_range(0, 399) != 0);
        end
        restart = 1'b0;
        reset_n = 1'b1;
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_lock_up();
        test_retry_fault();
        test_stable_glitch();
        test_loss_count();
        test_restart_on_loss();
        test_reset_mid_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
